// File: rtl/sum_tx_serializer_if.sv
// Byte handshake and serial-status bundle for sum_tx_serializer.
// The producer side uses master and the serializer uses slave.
interface sum_tx_serializer_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx_out;
    logic       busy;
    logic [3:0] fifo_level;
    logic       overflow;
    logic       clr_ovf;

    modport master (
        output in_data, in_valid, clr_ovf,
        input  in_ready, tx_out, busy, fifo_level, overflow
    );

    modport slave (
        input  in_data, in_valid, clr_ovf,
        output in_ready, tx_out, busy, fifo_level, overflow
    );
endinterface

// File: rtl/sum_tx_serializer.sv
// Buffers adder result bytes in a small FIFO and sends each one LSB-first as a UART-style frame.
// Define SUM_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module sum_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sum_tx_serializer_if.slave bus
);

    localparam int unsigned PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [7:0]  CntMax    = 8'(CLKS_PER_BIT - 1);
    localparam logic [3:0]  LevelFull = 4'(FIFO_DEPTH);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
`ifdef SUM_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif
    localparam logic [2:0] StStop   = 3'd4;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [3:0]      level_q, level_d;
    logic            ovf_q, ovf_d;

    logic [2:0]      state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
`ifdef SUM_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            in_ready;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            bit_done;
    logic [7:0]      head;

    // in_ready comes from registered level only, so a same-cycle pop cannot admit a push.
    assign in_ready   = (level_q != LevelFull);
    assign push       = bus.in_valid && in_ready;
    assign fifo_empty = (level_q == 4'd0);
    assign bit_done   = (cnt_q == CntMax);
    assign head       = mem_q[rptr_q];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 8'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef SUM_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                cnt_d = 8'd0;
                tx_d  = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef SUM_TX_PARITY_EN
                    par_d   = ^head;
`endif
                    state_d = StStart;
                    tx_d    = 1'b0;
                end
            end
            StStart: begin
                if (bit_done) begin
                    cnt_d   = 8'd0;
                    idx_d   = 3'd0;
                    state_d = StData;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_done) begin
                    cnt_d = 8'd0;
                    if (idx_q == 3'd7) begin
`ifdef SUM_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = par_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        // Bit 0 of the shift register is always the bit on the line.
                        idx_d   = idx_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
`ifdef SUM_TX_PARITY_EN
            StParity: begin
                if (bit_done) begin
                    cnt_d   = 8'd0;
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_done) begin
                    cnt_d = 8'd0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef SUM_TX_PARITY_EN
                        par_d   = ^head;
`endif
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
                tx_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        wptr_d  = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + PtrW'(1) : rptr_q;
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 4'd1;
        end else if (!push && pop) begin
            level_d = level_q - 4'd1;
        end
        // A refused byte sets the flag even when clr_ovf is asserted in the same cycle.
        if (bus.in_valid && !in_ready) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= 4'd0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SUM_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef SUM_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.tx_out     = tx_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;

endmodule
